// File: rtl/serdesphy_rx_align_ctrl.sv
// RX bring-up sequencer and word aligner. Enables the deserializer once the CDR is locked,
// finds SYNC_WORD at one of 16 bit offsets, verifies its period, tracks lock and emits aligned words.
module serdesphy_rx_align_ctrl #(
    parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
    parameter int unsigned SYNC_PERIOD = 64,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned LOSS_LIMIT  = 4
) (
    input  logic        clk_240m_rx,
    input  logic        rst_n,
    input  logic        rx_enable,
    input  logic        cdr_locked,
    input  logic [15:0] deser_data,
    input  logic        deser_valid,
    output logic        deser_enable,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        rx_is_sync,
    output logic        aligned,
    output logic [3:0]  align_offset,
    output logic        align_err,
    output logic [2:0]  state
);
    localparam int DATA_W = 16;
    localparam int WCNT_W = $clog2(SYNC_PERIOD);
    localparam int HITS_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CDR = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_VERIFY   = 3'd3,
        ST_LOCKED   = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   prev_q;
    logic                win_ok_q;
    logic                win_ok_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WCNT_W-1:0]   wcnt_d;
    logic [HITS_W-1:0]   hits_q;
    logic [HITS_W-1:0]   hits_d;
    logic [HITS_W-1:0]   hits_inc;
    logic [MISS_W-1:0]   misses_q;
    logic [MISS_W-1:0]   misses_d;
    logic [MISS_W-1:0]   misses_inc;
    logic [3:0]          offset_d;
    logic                out_valid_d;
    logic                out_sync_d;
    logic                err_d;

    logic [2*DATA_W-1:0] window;
    logic [DATA_W-1:0]   word_at_offset;
    logic                hit_any;
    logic [3:0]          hit_k;
    logic                slot;
    logic                slot_match;
    logic                active;

    // Previous word sits in the upper half, so larger offsets reach further back in the stream.
    assign window         = {prev_q, deser_data};
    assign word_at_offset = window[align_offset +: DATA_W];
    assign slot           = (wcnt_q == WCNT_W'(SYNC_PERIOD - 1));
    assign slot_match     = (word_at_offset == SYNC_WORD);
    assign hits_inc       = hits_q + 1'b1;
    assign misses_inc     = misses_q + 1'b1;
    assign active         = (state_q == ST_SEARCH) || (state_q == ST_VERIFY) || (state_q == ST_LOCKED);
    assign state          = state_q;

    // Scan from the top down so the lowest matching offset wins.
    always_comb begin
        hit_any = 1'b0;
        hit_k   = '0;
        for (int k = DATA_W - 1; k >= 0; k--) begin
            if (window[k +: DATA_W] == SYNC_WORD) begin
                hit_any = 1'b1;
                hit_k   = 4'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_ok_d    = win_ok_q;
        wcnt_d      = wcnt_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
        offset_d    = align_offset;
        out_valid_d = 1'b0;
        out_sync_d  = 1'b0;
        err_d       = 1'b0;

        if (!rx_enable) begin
            state_d  = ST_IDLE;
            win_ok_d = 1'b0;
            wcnt_d   = '0;
            hits_d   = '0;
            misses_d = '0;
        end else if (!cdr_locked && active) begin
            state_d  = ST_WAIT_CDR;
            win_ok_d = 1'b0;
            wcnt_d   = '0;
            hits_d   = '0;
            misses_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_CDR;
                ST_WAIT_CDR: begin
                    if (cdr_locked) begin
                        state_d  = ST_SEARCH;
                        win_ok_d = 1'b0;
                    end
                end
                ST_SEARCH: begin
                    if (deser_valid) begin
                        win_ok_d = 1'b1;
                        // The first word after entry has a stale upper half, so it is never matched.
                        if (win_ok_q && hit_any) begin
                            offset_d = hit_k;
                            wcnt_d   = '0;
                            hits_d   = HITS_W'(1);
                            state_d  = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (deser_valid) begin
                        wcnt_d = wcnt_q + 1'b1;
                        if (slot) begin
                            if (slot_match) begin
                                hits_d = hits_inc;
                                if (hits_inc == HITS_W'(LOCK_COUNT)) begin
                                    state_d     = ST_LOCKED;
                                    misses_d    = '0;
                                    out_valid_d = 1'b1;
                                    out_sync_d  = 1'b1;
                                end
                            end else begin
                                state_d  = ST_SEARCH;
                                win_ok_d = 1'b0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (deser_valid) begin
                        wcnt_d      = wcnt_q + 1'b1;
                        out_valid_d = 1'b1;
                        if (slot && slot_match) begin
                            misses_d   = '0;
                            out_sync_d = 1'b1;
                        end else if (slot) begin
                            misses_d = misses_inc;
                            if (misses_inc == MISS_W'(LOSS_LIMIT)) begin
                                state_d     = ST_SEARCH;
                                win_ok_d    = 1'b0;
                                err_d       = 1'b1;
                                out_valid_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_240m_rx or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            win_ok_q     <= 1'b0;
            wcnt_q       <= '0;
            hits_q       <= '0;
            misses_q     <= '0;
            align_offset <= '0;
            deser_enable <= 1'b0;
            aligned      <= 1'b0;
            align_err    <= 1'b0;
            rx_valid     <= 1'b0;
            rx_is_sync   <= 1'b0;
            rx_data      <= '0;
        end else begin
            state_q      <= state_d;
            win_ok_q     <= win_ok_d;
            wcnt_q       <= wcnt_d;
            hits_q       <= hits_d;
            misses_q     <= misses_d;
            align_offset <= offset_d;
            if (deser_valid) begin
                prev_q <= deser_data;
            end
            deser_enable <= active;
            aligned      <= (state_d == ST_LOCKED);
            align_err    <= err_d;
            rx_valid     <= out_valid_d;
            rx_is_sync   <= out_sync_d;
            if (out_valid_d) begin
                rx_data <= word_at_offset;
            end
        end
    end
endmodule

// File: tb/tb_serdesphy_rx_align_ctrl.sv
// Randomized scoreboard bench for serdesphy_rx_align_ctrl: a behavioural model predicts
// control outputs per cycle and queues expected aligned words for a separate monitor.
module tb_serdesphy_rx_align_ctrl;
    localparam logic [15:0] SYNC = 16'hA5C3;
    localparam int PERIOD = 64;
    localparam int LOCKN  = 4;
    localparam int LOSSN  = 4;
    localparam int K_NORMAL = 0;
    localparam int K_SYNC   = 1;
    localparam int K_DATA   = 2;
    localparam int LOCK_WORDS = 5 * PERIOD + 8;

    logic        clk;
    logic        rst_n;
    logic        rx_enable;
    logic        cdr_locked;
    logic [15:0] deser_data;
    logic        deser_valid;
    logic        deser_enable;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_is_sync;
    logic        aligned;
    logic [3:0]  align_offset;
    logic        align_err;
    logic [2:0]  state;

    serdesphy_rx_align_ctrl dut (
        .clk_240m_rx (clk),
        .rst_n       (rst_n),
        .rx_enable   (rx_enable),
        .cdr_locked  (cdr_locked),
        .deser_data  (deser_data),
        .deser_valid (deser_valid),
        .deser_enable(deser_enable),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_is_sync  (rx_is_sync),
        .aligned     (aligned),
        .align_offset(align_offset),
        .align_err   (align_err),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state (spec-level: state codes 0..4, plain integers)
    int          m_state, m_offset, m_wcnt, m_hits, m_misses;
    bit          m_winok, m_deser_en, m_aligned, m_err;
    logic [15:0] m_prev;
    bit          exp_out, exp_sync;
    logic [16:0] exp_q[$];

    task automatic model_reset();
        m_state = 0; m_offset = 0; m_wcnt = 0; m_hits = 0; m_misses = 0;
        m_winok = 0; m_deser_en = 0; m_aligned = 0; m_err = 0; m_prev = '0;
        exp_out = 0; exp_sync = 0;
    endtask

    function automatic int find_sync(input logic [31:0] w);
        for (int s = 0; s < 16; s++) begin
            if (16'(w >> s) == SYNC) return s;
        end
        return -1;
    endfunction

    task automatic model_step(input bit en, input bit cdr, input bit v, input logic [15:0] d);
        logic [31:0] w;
        logic [15:0] wk;
        int ns, hit;
        bit at_slot;
        w = {m_prev, d};
        wk = 16'(w >> m_offset);
        m_err = 0; exp_out = 0; exp_sync = 0;
        m_deser_en = (m_state >= 2);
        ns = m_state;
        if (!en || (!cdr && m_state >= 2)) begin
            ns = en ? 1 : 0;
            m_wcnt = 0; m_hits = 0; m_misses = 0; m_winok = 0;
        end else if (m_state == 0) begin
            ns = 1;
        end else if (m_state == 1) begin
            if (cdr) begin ns = 2; m_winok = 0; end
        end else if (v) begin
            at_slot = (m_wcnt == PERIOD - 1);
            if (m_state == 2) begin
                hit = find_sync(w);
                if (m_winok && hit >= 0) begin
                    m_offset = hit; m_wcnt = 0; m_hits = 1; ns = 3;
                end
                m_winok = 1;
            end else begin
                m_wcnt = (m_wcnt + 1) % PERIOD;
                if (m_state == 3) begin
                    if (at_slot && wk == SYNC) begin
                        m_hits++;
                        if (m_hits == LOCKN) begin
                            ns = 4; m_misses = 0; exp_out = 1; exp_sync = 1;
                        end
                    end else if (at_slot) begin
                        ns = 2; m_winok = 0;
                    end
                end else begin
                    exp_out = 1;
                    if (at_slot && wk == SYNC) begin
                        m_misses = 0; exp_sync = 1;
                    end else if (at_slot) begin
                        m_misses++;
                        if (m_misses == LOSSN) begin
                            ns = 2; m_err = 1; m_winok = 0; exp_out = 0;
                        end
                    end
                end
            end
        end
        if (v) m_prev = d;
        m_aligned = (ns == 4);
        m_state = ns;
    endtask

    // Monitor: compares every cycle against the model and pops the scoreboard on output words
    int err_cnt = 0, verify_cycles = 0, aligned_cycles = 0, out_cnt = 0;
    logic [16:0] mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            check("state", 32'(state), 32'(m_state));
            check("aligned", 32'(aligned), 32'(m_aligned));
            check("align_err", 32'(align_err), 32'(m_err));
            check("deser_enable", 32'(deser_enable), 32'(m_deser_en));
            check("align_offset", 32'(align_offset), 32'(m_offset));
            check("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                if (rx_valid) begin
                    check("rx_data", 32'(rx_data), 32'(mon_e[15:0]));
                    check("rx_is_sync", 32'(rx_is_sync), 32'(mon_e[16]));
                end
            end else begin
                check("rx_is_sync_idle", 32'(rx_is_sync), 32'(0));
            end
            if (align_err) err_cnt++;
            if (state == 3'd3) verify_cycles++;
            if (aligned) aligned_cycles++;
            if (rx_valid) out_cnt++;
        end
    end

    task automatic cycle(input bit en, input bit cdr, input bit v,
                         input logic [15:0] d, input logic [15:0] ref_w);
        rx_enable = en; cdr_locked = cdr; deser_valid = v; deser_data = d;
        @(posedge clk);
        model_step(en, cdr, v, d);
        if (exp_out) exp_q.push_back({exp_sync, ref_w});
        #1;
    endtask

    // Transmit-side stream generator
    int          tx_k, tx_idx, corrupt_left;
    bit          gaps;
    logic [15:0] tx_prev;

    function automatic logic [15:0] rand_data(input logic [15:0] prevt);
        logic [15:0] t;
        bit ok;
        do begin
            t = 16'($urandom);
            ok = (t != SYNC);
            for (int s = 1; s < 16; s++) begin
                if (16'({prevt, t} >> s) == SYNC) ok = 0;
                if (16'({t, SYNC} >> s) == SYNC) ok = 0;
            end
        end while (!ok);
        return t;
    endfunction

    task automatic send_word(input int kind);
        logic [15:0] t, dw, ref_w;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) cycle(1, 1, 0, 16'($urandom), 16'h0);
        end
        if (kind == K_SYNC || (kind == K_NORMAL && tx_idx == 0)) begin
            t = SYNC;
            if (kind == K_NORMAL && corrupt_left > 0) begin
                t = SYNC ^ 16'h8000;
                corrupt_left--;
            end
        end else begin
            t = rand_data(tx_prev);
        end
        // The deserializer word lags the transmit word boundary by 16-k bits.
        dw = 16'({tx_prev, t} >> (16 - tx_k));
        ref_w = tx_prev;
        tx_prev = t;
        tx_idx = (tx_idx + 1) % PERIOD;
        cycle(1, 1, 1, dw, ref_w);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_word(K_NORMAL);
    endtask

    task automatic start_stream(input int k, input bit g);
        cycle(0, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 0, 16'h0, 16'h0);
        cycle(1, 1, 0, 16'h0, 16'h0);
        cycle(1, 1, 0, 16'h0, 16'h0);
        tx_k = k; gaps = g; corrupt_left = 0;
        tx_idx = $urandom_range(0, PERIOD - 1);
        tx_prev = 16'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int e0, v0, a0, o0;
    initial begin
        rst_n = 1'b0; rx_enable = 0; cdr_locked = 0; deser_valid = 0; deser_data = '0;
        model_reset();
        tx_k = 0; tx_idx = 0; corrupt_left = 0; gaps = 0; tx_prev = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_deser_enable", 32'(deser_enable), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_aligned", 32'(aligned), 0);
        check("rst_align_offset", 32'(align_offset), 0);
        check("rst_align_err", 32'(align_err), 0);
        rst_n = 1'b1;

        // Bring-up
        repeat (3) cycle(1, 0, 0, 16'h0, 16'h0);
        check("bringup_wait_state", 32'(state), 1);
        check("bringup_wait_deser_en", 32'(deser_enable), 0);
        cycle(1, 1, 0, 16'h0, 16'h0);
        check("bringup_search_state", 32'(state), 2);
        check("bringup_deser_en_lag", 32'(deser_enable), 0);
        cycle(1, 1, 0, 16'h0, 16'h0);
        check("bringup_deser_en", 32'(deser_enable), 1);

        // Offset sweep, odd offsets with idle gaps between words
        for (int k = 0; k < 16; k++) begin
            start_stream(k, bit'(k % 2));
            o0 = out_cnt;
            send_n(LOCK_WORDS);
            check("sweep_offset", 32'(align_offset), 32'(k));
            check("sweep_aligned", 32'(aligned), 1);
            check("sweep_outputs", 32'(out_cnt - o0 >= PERIOD), 1);
        end

        // False lock: one isolated sync image
        start_stream(3, 0);
        e0 = err_cnt; v0 = verify_cycles; a0 = aligned_cycles;
        for (int i = 0; i < 6; i++) send_word(K_DATA);
        send_word(K_SYNC);
        for (int i = 0; i < PERIOD + 10; i++) send_word(K_DATA);
        check("false_lock_verify_seen", 32'(verify_cycles - v0 > 0), 1);
        check("false_lock_aligned", 32'(aligned_cycles - a0), 0);
        check("false_lock_err", 32'(err_cnt - e0), 0);
        check("false_lock_state", 32'(state), 2);

        // Loss of alignment
        start_stream(7, 0);
        send_n(LOCK_WORDS);
        e0 = err_cnt;
        corrupt_left = 3;
        send_n(3 * PERIOD);
        check("loss3_state", 32'(state), 4);
        check("loss3_err", 32'(err_cnt - e0), 0);
        corrupt_left = 1;
        send_n(PERIOD + 2);
        check("loss4_err_pulses", 32'(err_cnt - e0), 1);
        check("loss4_state", 32'(state), 2);
        check("loss4_aligned", 32'(aligned), 0);
        o0 = out_cnt;
        send_n(20);
        check("loss_rx_valid_stopped", 32'(out_cnt - o0), 0);

        // Recovery: a good slot between bad runs resets the miss count
        send_n(LOCK_WORDS);
        check("recover_relock", 32'(state), 4);
        e0 = err_cnt;
        corrupt_left = 3;
        send_n(4 * PERIOD);
        corrupt_left = 3;
        send_n(3 * PERIOD + 2);
        check("recover_err", 32'(err_cnt - e0), 0);
        check("recover_state", 32'(state), 4);

        // Overrides
        e0 = err_cnt;
        cycle(1, 0, 0, 16'h0, 16'h0);
        check("ovr_cdr_state", 32'(state), 1);
        check("ovr_cdr_aligned", 32'(aligned), 0);
        cycle(1, 0, 0, 16'h0, 16'h0);
        check("ovr_cdr_deser_en", 32'(deser_enable), 0);
        check("ovr_cdr_err", 32'(err_cnt - e0), 0);
        cycle(1, 1, 0, 16'h0, 16'h0);
        send_n(LOCK_WORDS);
        check("ovr_relock", 32'(state), 4);
        cycle(0, 0, 0, 16'h0, 16'h0);
        check("ovr_both_state", 32'(state), 0);
        check("ovr_both_err", 32'(err_cnt - e0), 0);

        // Asynchronous reset mid-word while locked
        start_stream(11, 0);
        send_n(LOCK_WORDS);
        deser_valid = 1'b1;
        deser_data = 16'($urandom);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_deser_enable", 32'(deser_enable), 0);
        check("arst_rx_valid", 32'(rx_valid), 0);
        check("arst_rx_data", 32'(rx_data), 0);
        check("arst_rx_is_sync", 32'(rx_is_sync), 0);
        check("arst_aligned", 32'(aligned), 0);
        check("arst_align_offset", 32'(align_offset), 0);
        check("arst_align_err", 32'(align_err), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, 0, 16'h0, 16'h0);
        check("arst_restart_state", 32'(state), 1);
        cycle(1, 0, 0, 16'h0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
